// File: rtl/axis_register_slice.sv
// Single-stage AXI4-Stream register slice (skid buffer): every forward field and the
// backward tready are registered. Define AXIS_REGISTER_SLICE_TSTRB_TKEEP_EN to carry tstrb/tkeep.
module axis_register_slice #(
    parameter int N = 8,
    parameter int I = 1,
    parameter int D = 1,
    parameter int U = 1
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           axis_in_tvalid,
    output logic           axis_in_tready,
    input  logic [N*8-1:0] axis_in_tdata,
    input  logic [I-1:0]   axis_in_tid,
    input  logic [D-1:0]   axis_in_tdest,
    input  logic [U-1:0]   axis_in_tuser,
    input  logic           axis_in_tlast,
`ifdef AXIS_REGISTER_SLICE_TSTRB_TKEEP_EN
    input  logic [N-1:0]   axis_in_tstrb,
    input  logic [N-1:0]   axis_in_tkeep,
    output logic [N-1:0]   axis_out_tstrb,
    output logic [N-1:0]   axis_out_tkeep,
`endif
    output logic           axis_out_tvalid,
    input  logic           axis_out_tready,
    output logic [N*8-1:0] axis_out_tdata,
    output logic [I-1:0]   axis_out_tid,
    output logic [D-1:0]   axis_out_tdest,
    output logic [U-1:0]   axis_out_tuser,
    output logic           axis_out_tlast
);

`ifdef AXIS_REGISTER_SLICE_TSTRB_TKEEP_EN
    localparam int W = N*8 + 2*N + I + D + U + 1;
`else
    localparam int W = N*8 + I + D + U + 1;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    logic [W-1:0] in_word_s;
    logic [W-1:0] out_word_r;
    logic [W-1:0] skid_word_r;
    logic         out_valid_r;
    logic         skid_valid_r;
    logic         in_ready_r;
    logic         out_valid_s;
    logic         skid_valid_s;
    logic         load_out_in_s;
    logic         load_out_skid_s;
    logic         load_skid_s;
    logic         accept_s;
    logic         deliver_s;
    state_e       state_s;

`ifdef AXIS_REGISTER_SLICE_TSTRB_TKEEP_EN
    assign in_word_s = {axis_in_tstrb, axis_in_tkeep, axis_in_tdata, axis_in_tid,
                        axis_in_tdest, axis_in_tuser, axis_in_tlast};
    assign {axis_out_tstrb, axis_out_tkeep, axis_out_tdata, axis_out_tid,
            axis_out_tdest, axis_out_tuser, axis_out_tlast} = out_word_r;
`else
    assign in_word_s = {axis_in_tdata, axis_in_tid, axis_in_tdest, axis_in_tuser, axis_in_tlast};
    assign {axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tuser, axis_out_tlast} = out_word_r;
`endif

    assign axis_in_tready  = in_ready_r;
    assign axis_out_tvalid = out_valid_r;
    assign accept_s        = axis_in_tvalid & in_ready_r;
    assign deliver_s       = out_valid_r & axis_out_tready;
    assign state_s         = state_e'({out_valid_r, skid_valid_r});

    // Next-state and register-load decode for the EMPTY/ONE/FULL occupancy states.
    always_comb begin
        out_valid_s     = out_valid_r;
        skid_valid_s    = skid_valid_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        case (state_s)
            EMPTY: begin
                if (accept_s) begin
                    out_valid_s   = 1'b1;
                    load_out_in_s = 1'b1;
                end else begin
                    out_valid_s   = 1'b0;
                end
            end
            ONE: begin
                if (accept_s && deliver_s) begin
                    load_out_in_s = 1'b1;
                end else if (accept_s) begin
                    skid_valid_s  = 1'b1;
                    load_skid_s   = 1'b1;
                end else if (deliver_s) begin
                    out_valid_s   = 1'b0;
                end else begin
                    out_valid_s   = 1'b1;
                end
            end
            FULL: begin
                // tready is low here, so the only possible event is a delivery
                if (deliver_s) begin
                    skid_valid_s    = 1'b0;
                    load_out_skid_s = 1'b1;
                end else begin
                    skid_valid_s    = 1'b1;
                end
            end
            default: begin
                out_valid_s  = 1'b0;
                skid_valid_s = 1'b0;
            end
        endcase
    end

    // Occupancy flags and the registered upstream ready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= ~skid_valid_s;
        end
    end

    // Payload registers; contents are meaningless while the matching valid is low.
    always_ff @(posedge aclk) begin
        if (load_out_in_s) begin
            out_word_r <= in_word_s;
        end else if (load_out_skid_s) begin
            out_word_r <= skid_word_r;
        end else begin
            out_word_r <= out_word_r;
        end
        if (load_skid_s) begin
            skid_word_r <= in_word_s;
        end else begin
            skid_word_r <= skid_word_r;
        end
    end

endmodule

// File: tb/tb_axis_register_slice.sv
// Directed and scoreboarded bench for axis_register_slice (N=2, I=D=U=4).
module tb_axis_register_slice;
    localparam int N = 2;
    localparam int I = 4;
    localparam int D = 4;
    localparam int U = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [15:0] in_data, out_data;
    logic [3:0]  in_id, in_dest, in_user, out_id, out_dest, out_user;
`ifdef AXIS_REGISTER_SLICE_TSTRB_TKEEP_EN
    logic [1:0]  in_strb, in_keep, out_strb, out_keep;
`endif
    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axis_register_slice #(.N(N), .I(I), .D(D), .U(U)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .axis_in_tvalid(in_valid), .axis_in_tready(in_ready), .axis_in_tdata(in_data),
        .axis_in_tid(in_id), .axis_in_tdest(in_dest), .axis_in_tuser(in_user),
        .axis_in_tlast(in_last),
`ifdef AXIS_REGISTER_SLICE_TSTRB_TKEEP_EN
        .axis_in_tstrb(in_strb), .axis_in_tkeep(in_keep),
        .axis_out_tstrb(out_strb), .axis_out_tkeep(out_keep),
`endif
        .axis_out_tvalid(out_valid), .axis_out_tready(out_ready), .axis_out_tdata(out_data),
        .axis_out_tid(out_id), .axis_out_tdest(out_dest), .axis_out_tuser(out_user),
        .axis_out_tlast(out_last)
    );

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        il;
        logic        ordy;
        logic        ev;
        logic [15:0] ed;
        logic        el;
        logic        erdy;
    } vec_t;
    vec_t vecs[9];
    logic [31:0] sb[$];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [15:0] d, input logic l);
        return {3'b000, d, d[3:0], d[7:4], d[11:8], l};
    endfunction

    function automatic logic [31:0] out_word();
        return {3'b000, out_data, out_id, out_dest, out_user, out_last};
    endfunction

    task automatic drive_full(input logic v, input logic [15:0] d, input logic [3:0] i,
                              input logic [3:0] t, input logic [3:0] u, input logic l,
                              input logic r);
        in_valid  = v;
        in_data   = d;
        in_id     = i;
        in_dest   = t;
        in_user   = u;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic r);
        drive_full(v, d, d[3:0], d[7:4], d[11:8], l, r);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [31:0] held = 32'd0;
        logic [31:0] bt;
        logic [15:0] bd;

        vecs[0] = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'hCCCC, 1'b0, 1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'h5678, 1'b0, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 16'h9ABC, 1'b1, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};

        drive(1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef AXIS_REGISTER_SLICE_TSTRB_TKEEP_EN
        in_strb = 2'b11;
        in_keep = 2'b11;
`endif
        // Reset held for three clocks
        for (int k = 0; k < 3; k++) begin
            step();
            check_bit("rst_out_valid", out_valid, 1'b0);
            check_bit("rst_in_ready", in_ready, 1'b0);
        end
        aresetn = 1'b1;
        #1;
        check_bit("release_ready_before_edge", in_ready, 1'b0);
        step();
        check_bit("release_ready_after_edge", in_ready, 1'b1);
        check_bit("release_out_valid", out_valid, 1'b0);

        // Backpressure and corner-case table
        for (int k = 0; k < 9; k++) begin
            drive(vecs[k].iv, vecs[k].id, vecs[k].il, vecs[k].ordy);
            step();
            check_bit($sformatf("vec%0d_valid", k), out_valid, vecs[k].ev);
            check_bit($sformatf("vec%0d_in_ready", k), in_ready, vecs[k].erdy);
            if (vecs[k].ev)
                check_word($sformatf("vec%0d_word", k), out_word(), word_of(vecs[k].ed, vecs[k].el));
        end

        // Streaming 16 beats, tlast on the last
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 16'(i), (i == 16), 1'b1);
            step();
            check_bit($sformatf("stream%0d_valid", i), out_valid, 1'b1);
            check_bit($sformatf("stream%0d_in_ready", i), in_ready, 1'b1);
            check_word($sformatf("stream%0d_word", i), out_word(), word_of(16'(i), (i == 16)));
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        check_bit("stream_drained", out_valid, 1'b0);

`ifdef AXIS_REGISTER_SLICE_TSTRB_TKEEP_EN
        drive(1'b1, 16'h00F0, 1'b1, 1'b1);
        in_strb = 2'b01;
        in_keep = 2'b01;
        step();
        check_word("strb_keep_word", out_word(), word_of(16'h00F0, 1'b1));
        check_word("strb_keep", {28'd0, out_strb, out_keep}, 32'h0000_0005);
        in_strb = 2'b11;
        in_keep = 2'b11;
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
`endif

        // Random valid/ready with scoreboard and stall-stability checks
        while (got < 1000 && cyc < 20000) begin
            bd = 16'(sent * 37) ^ 16'h5A5A;
            bt = {3'b000, bd, 4'(sent), 4'(sent + 3), 4'(sent + 7), (sent % 5 == 4)};
            drive_full((sent < 1000) && ($urandom_range(0, 3) != 0), bd, 4'(sent), 4'(sent + 3),
                       4'(sent + 7), (sent % 5 == 4), ($urandom_range(0, 2) != 0));
            if (stalled)
                check_word("stall_stable", {out_word()[30:0], out_valid}, {held[30:0], 1'b1});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected actual=%h required=none", out_word());
                end else begin
                    check_word($sformatf("rand_beat%0d", got), out_word(), sb.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(bt);
                sent++;
            end
            stalled = out_valid && !out_ready;
            held = out_word();
            step();
            cyc++;
        end
        check_word("rand_delivered", 32'(got), 32'd1000);
        check_word("rand_sb_empty", 32'(sb.size()), 32'd0);

        // Fill to FULL, then reset asynchronously mid-cycle
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
        step();
        check_bit("full_in_ready", in_ready, 1'b0);
        check_bit("full_out_valid", out_valid, 1'b1);
        aresetn = 1'b0;
        #1;
        check_bit("async_rst_out_valid", out_valid, 1'b0);
        check_bit("async_rst_in_ready", in_ready, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        step();
        aresetn = 1'b1;
        step();
        check_bit("post_rst_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check_bit("post_rst_no_stale", out_valid, 1'b0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
